// File: rtl/fb_write_scheduler_if.sv
// fb_write_scheduler_if: client request, clear-control and framebuffer write signals
// shared by the drawing clients and the write scheduler.
`default_nettype none

interface fb_write_scheduler_if;
    logic        c0_valid;
    logic [10:0] c0_x;
    logic [10:0] c0_y;
    logic        c0_color;
    logic        c0_ack;
    logic        c1_valid;
    logic [10:0] c1_x;
    logic [10:0] c1_y;
    logic        c1_color;
    logic        c1_ack;
    logic        clear_start;
    logic        clear_color;
    logic        clear_busy;
    logic        clear_done;
    logic        oob_drop;
    logic [10:0] x;
    logic [10:0] y;
    logic        pixel_color;
    logic        pixel_write;

    modport master (
        output c0_valid, c0_x, c0_y, c0_color,
        output c1_valid, c1_x, c1_y, c1_color,
        output clear_start, clear_color,
        input  c0_ack, c1_ack, clear_busy, clear_done, oob_drop,
        input  x, y, pixel_color, pixel_write
    );

    modport slave (
        input  c0_valid, c0_x, c0_y, c0_color,
        input  c1_valid, c1_x, c1_y, c1_color,
        input  clear_start, clear_color,
        output c0_ack, c1_ack, clear_busy, clear_done, oob_drop,
        output x, y, pixel_color, pixel_write
    );
endinterface

`default_nettype wire

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: round-robin arbiter for two clients onto the single framebuffer
// write port, plus a raster-order clear-screen sequencer that owns the port while active.
`default_nettype none

module fb_write_scheduler #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic               clk50,
    input  logic               reset,
    fb_write_scheduler_if.slave bus
);

    localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
    localparam logic [10:0] Y_LAST = 11'(HEIGHT - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [10:0] cx_q, cx_d;
    logic [10:0] cy_q, cy_d;
    logic        clr_color_q, clr_color_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        color_q, color_d;
    logic        write_q, write_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        oob_q, oob_d;

    logic        ack0;
    logic        ack1;
    logic [10:0] sel_x;
    logic [10:0] sel_y;
    logic        sel_color;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cx_q         <= '0;
            cy_q         <= '0;
            clr_color_q  <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            color_q      <= 1'b0;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            clr_color_q  <= clr_color_d;
            x_q          <= x_d;
            y_q          <= y_d;
            color_q      <= color_d;
            write_q      <= write_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            oob_q        <= oob_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        clr_color_d  = clr_color_q;
        x_d          = x_q;
        y_d          = y_q;
        color_d      = color_q;
        write_d      = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        oob_d        = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        sel_x        = bus.c0_x;
        sel_y        = bus.c0_y;
        sel_color    = bus.c0_color;

        case (state_q)
            IDLE: begin
                if (bus.clear_start) begin
                    // First clear write is issued on the same edge that enters CLEAR.
                    state_d     = CLEAR;
                    cx_d        = '0;
                    cy_d        = '0;
                    clr_color_d = bus.clear_color;
                    x_d         = '0;
                    y_d         = '0;
                    color_d     = bus.clear_color;
                    write_d     = 1'b1;
                    busy_d      = 1'b1;
                end else if (!done_q) begin
                    // The clear_done cycle still belongs to the sweep; clients wait one more cycle.
                    if (bus.c0_valid && (!bus.c1_valid || last_grant_q)) begin
                        ack0 = 1'b1;
                    end else if (bus.c1_valid) begin
                        ack1 = 1'b1;
                    end
                    if (ack1) begin
                        sel_x     = bus.c1_x;
                        sel_y     = bus.c1_y;
                        sel_color = bus.c1_color;
                    end
                    if (ack0 || ack1) begin
                        last_grant_d = ack1;
                        if ((sel_x > X_LAST) || (sel_y > Y_LAST)) begin
                            oob_d = 1'b1;
                        end else begin
                            x_d     = sel_x;
                            y_d     = sel_y;
                            color_d = sel_color;
                            write_d = 1'b1;
                        end
                    end
                end
            end
            CLEAR: begin
                if ((cx_q == X_LAST) && (cy_q == Y_LAST)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    if (cx_q == X_LAST) begin
                        cx_d = '0;
                        cy_d = cy_q + 11'd1;
                    end else begin
                        cx_d = cx_q + 11'd1;
                    end
                    x_d     = cx_d;
                    y_d     = cy_d;
                    color_d = clr_color_q;
                    write_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.c0_ack      = ack0;
    assign bus.c1_ack      = ack1;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.pixel_color = color_q;
    assign bus.pixel_write = write_q;
    assign bus.clear_busy  = busy_q;
    assign bus.clear_done  = done_q;
    assign bus.oob_drop    = oob_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: directed scenarios for fb_write_scheduler on a reduced 16x8 screen
// so a full clear sweep stays short.
`default_nettype none

module tb_fb_write_scheduler;

    localparam int W = 16;
    localparam int H = 8;
    localparam int N = W * H;

    logic clk50 = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    fb_write_scheduler_if bus ();

    fb_write_scheduler #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk50 (clk50),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk50 = ~clk50;

    task automatic idle_inputs();
        bus.c0_valid = 0; bus.c0_x = 0; bus.c0_y = 0; bus.c0_color = 0;
        bus.c1_valid = 0; bus.c1_x = 0; bus.c1_y = 0; bus.c1_color = 0;
        bus.clear_start = 0; bus.clear_color = 0;
    endtask

    task automatic do_reset();
        @(negedge clk50);
        reset = 1'b1;
        @(posedge clk50);
        @(negedge clk50);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [26:0] outs;
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        outs = {bus.x, bus.y, bus.pixel_color, bus.pixel_write, bus.clear_busy,
                bus.clear_done, bus.oob_drop};
        total++;
        if (outs !== 27'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", outs);
        end
        @(negedge clk50);
        reset = 1'b0;
        bus.c1_valid = 1'b0;
        #1;
        total++;
        if ({bus.c0_ack, bus.c1_ack} !== 2'b00) begin
            bad++; $display("FAIL reset_no_ack got=%b want=00", {bus.c0_ack, bus.c1_ack});
        end
    endtask

    task automatic test_single_write();
        @(negedge clk50);
        bus.c0_valid = 1; bus.c0_x = 5; bus.c0_y = 7; bus.c0_color = 1;
        #1;
        total++;
        if ({bus.c0_ack, bus.c1_ack} !== 2'b10) begin
            bad++; $display("FAIL single_ack got=%b want=10", {bus.c0_ack, bus.c1_ack});
        end
        @(posedge clk50); #1;
        bus.c0_valid = 0;
        total++;
        if ({bus.pixel_write, bus.pixel_color, bus.x, bus.y} !== {1'b1, 1'b1, 11'd5, 11'd7}) begin
            bad++; $display("FAIL single_write got w=%b c=%b x=%0d y=%0d want w=1 c=1 x=5 y=7",
                            bus.pixel_write, bus.pixel_color, bus.x, bus.y);
        end
        @(posedge clk50); #1;
        total++;
        if (bus.pixel_write !== 1'b0) begin
            bad++; $display("FAIL single_idle_write got=%b want=0", bus.pixel_write);
        end
    endtask

    task automatic test_round_robin();
        logic e0;
        do_reset();
        bus.c0_valid = 1; bus.c0_x = 1; bus.c0_y = 2; bus.c0_color = 0;
        bus.c1_valid = 1; bus.c1_x = 3; bus.c1_y = 4; bus.c1_color = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            e0 = (i % 2 == 0);
            total++;
            if ({bus.c0_ack, bus.c1_ack} !== {e0, ~e0}) begin
                bad++; $display("FAIL rr_ack[%0d] got=%b want=%b", i,
                                {bus.c0_ack, bus.c1_ack}, {e0, ~e0});
            end
            @(posedge clk50); #1;
            total++;
            if ({bus.pixel_write, bus.pixel_color, bus.x, bus.y} !==
                (e0 ? {1'b1, 1'b0, 11'd1, 11'd2} : {1'b1, 1'b1, 11'd3, 11'd4})) begin
                bad++; $display("FAIL rr_write[%0d] got w=%b c=%b x=%0d y=%0d", i,
                                bus.pixel_write, bus.pixel_color, bus.x, bus.y);
            end
        end
        idle_inputs();
        @(posedge clk50); #1;
    endtask

    task automatic test_clear_sweep();
        int errs;
        errs = 0;
        @(negedge clk50);
        bus.clear_start = 1; bus.clear_color = 1;
        bus.c1_valid = 1; bus.c1_x = 9; bus.c1_y = 3; bus.c1_color = 0;
        #1;
        total++;
        if (bus.c1_ack !== 1'b0) begin
            bad++; $display("FAIL clear_vs_client_ack got=%b want=0", bus.c1_ack);
        end
        @(posedge clk50); #1;
        bus.clear_start = 0;
        for (int k = 0; k < N; k++) begin
            if ({bus.clear_busy, bus.pixel_write, bus.pixel_color, bus.c1_ack, bus.clear_done,
                 bus.x, bus.y} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'(k % W), 11'(k / W)}) begin
                if (errs < 4)
                    $display("FAIL clear_step[%0d] got busy=%b w=%b c=%b ack1=%b done=%b x=%0d y=%0d want x=%0d y=%0d",
                             k, bus.clear_busy, bus.pixel_write, bus.pixel_color, bus.c1_ack,
                             bus.clear_done, bus.x, bus.y, k % W, k / W);
                errs++;
            end
            // A second start with a different colour mid-sweep must be ignored.
            bus.clear_start = (k == 5); bus.clear_color = (k == 5) ? 1'b0 : 1'b1;
            @(posedge clk50); #1;
        end
        bus.clear_start = 0;
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL clear_sweep got=%0d bad cycles want=0", errs);
        end
        total++;
        if ({bus.clear_done, bus.clear_busy, bus.pixel_write, bus.c1_ack} !== 4'b1000) begin
            bad++; $display("FAIL clear_done_cycle got done,busy,w,ack1=%b want=1000",
                            {bus.clear_done, bus.clear_busy, bus.pixel_write, bus.c1_ack});
        end
        @(posedge clk50); #1;
        total++;
        if ({bus.clear_done, bus.c1_ack} !== 2'b01) begin
            bad++; $display("FAIL clear_after_done got done,ack1=%b want=01",
                            {bus.clear_done, bus.c1_ack});
        end
        @(posedge clk50); #1;
        bus.c1_valid = 0;
        total++;
        if ({bus.pixel_write, bus.x, bus.y} !== {1'b1, 11'd9, 11'd3}) begin
            bad++; $display("FAIL pending_c1_write got w=%b x=%0d y=%0d want w=1 x=9 y=3",
                            bus.pixel_write, bus.x, bus.y);
        end
        @(posedge clk50); #1;
    endtask

    task automatic test_oob();
        @(negedge clk50);
        bus.c0_valid = 1; bus.c0_x = 11'(W); bus.c0_y = 0; bus.c0_color = 1;
        #1;
        total++;
        if (bus.c0_ack !== 1'b1) begin
            bad++; $display("FAIL oob_x_ack got=%b want=1", bus.c0_ack);
        end
        @(posedge clk50); #1;
        bus.c0_x = 0; bus.c0_y = 11'(H);
        total++;
        if ({bus.pixel_write, bus.oob_drop} !== 2'b01) begin
            bad++; $display("FAIL oob_x_drop got w,oob=%b want=01", {bus.pixel_write, bus.oob_drop});
        end
        total++;
        if (bus.c0_ack !== 1'b1) begin
            bad++; $display("FAIL oob_y_ack got=%b want=1", bus.c0_ack);
        end
        @(posedge clk50); #1;
        bus.c0_x = 11'(W - 1); bus.c0_y = 11'(H - 1);
        total++;
        if ({bus.pixel_write, bus.oob_drop} !== 2'b01) begin
            bad++; $display("FAIL oob_y_drop got w,oob=%b want=01", {bus.pixel_write, bus.oob_drop});
        end
        @(posedge clk50); #1;
        bus.c0_valid = 0;
        total++;
        if ({bus.pixel_write, bus.oob_drop, bus.x, bus.y} !==
            {1'b1, 1'b0, 11'(W - 1), 11'(H - 1)}) begin
            bad++; $display("FAIL edge_in_range got w=%b oob=%b x=%0d y=%0d want w=1 oob=0 x=%0d y=%0d",
                            bus.pixel_write, bus.oob_drop, bus.x, bus.y, W - 1, H - 1);
        end
        @(posedge clk50); #1;
    endtask

    task automatic test_reset_mid_clear();
        int dones;
        dones = 0;
        @(negedge clk50);
        bus.clear_start = 1; bus.clear_color = 1;
        @(posedge clk50); #1;
        bus.clear_start = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk50); #1;
        end
        total++;
        if ({bus.clear_busy, bus.x, bus.y} !== {1'b1, 11'(50 % W), 11'(50 / W)}) begin
            bad++; $display("FAIL midclear_pos got busy=%b x=%0d y=%0d want busy=1 x=%0d y=%0d",
                            bus.clear_busy, bus.x, bus.y, 50 % W, 50 / W);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.x, bus.y, bus.pixel_color, bus.pixel_write, bus.clear_busy, bus.clear_done,
             bus.oob_drop} !== 27'd0) begin
            bad++; $display("FAIL midclear_reset_outputs got busy=%b w=%b x=%0d y=%0d want 0",
                            bus.clear_busy, bus.pixel_write, bus.x, bus.y);
        end
        @(posedge clk50);
        @(negedge clk50);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk50); #1;
            if (bus.clear_done !== 1'b0 || bus.clear_busy !== 1'b0) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL midclear_no_done got=%0d active cycles want=0", dones);
        end
        @(negedge clk50);
        bus.clear_start = 1; bus.clear_color = 0;
        @(posedge clk50); #1;
        bus.clear_start = 0;
        total++;
        if ({bus.clear_busy, bus.pixel_write, bus.pixel_color, bus.x, bus.y} !==
            {1'b1, 1'b1, 1'b0, 11'd0, 11'd0}) begin
            bad++; $display("FAIL restart_first got busy=%b w=%b c=%b x=%0d y=%0d want 1 1 0 0 0",
                            bus.clear_busy, bus.pixel_write, bus.pixel_color, bus.x, bus.y);
        end
        @(posedge clk50); #1;
        total++;
        if ({bus.x, bus.y} !== {11'd1, 11'd0}) begin
            bad++; $display("FAIL restart_second got x=%0d y=%0d want x=1 y=0", bus.x, bus.y);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_clear_sweep();
        test_oob();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
